// File: rtl/logic_arbiter.sv
// rtl/logic_arbiter.sv - round-robin arbiter sharing one logic unit between requesters A and B
// Accept in IDLE, drive the unit in EXEC, hold the tagged result in RESP until taken.
module logic_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [3:0]       a_x,
  input  logic [3:0]       a_y,
  input  logic [1:0]       a_sel,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [3:0]       b_x,
  input  logic [3:0]       b_y,
  input  logic [1:0]       b_sel,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic [1:0]       alu_select,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_b;
  logic   cur_id;
  logic   pick_b;
  logic   accept;

  // B wins when it is alone, or when both ask and A was granted last.
  always_comb begin
    pick_b  = b_valid && (!a_valid || !last_b);
    a_ready = !reset && (state == IDLE) && a_valid && !pick_b;
    b_ready = !reset && (state == IDLE) && pick_b;
    accept  = a_ready || b_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      cur_id     <= 1'b0;
      alu_x      <= 4'h0;
      alu_y      <= 4'h0;
      alu_select <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 8'h00;
      busy       <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The alu_* registers double as the latched operands.
            alu_x      <= pick_b ? b_x : a_x;
            alu_y      <= pick_b ? b_y : a_y;
            alu_select <= pick_b ? b_sel : a_sel;
            cur_id     <= pick_b;
            last_b     <= pick_b;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= (alu_select == 2'b11) ? alu_out : {4'h0, alu_out[3:0]};
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
